// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: per-port request/grant bundle plus the shared SRAM_Controller port and
// the tagged read-return path of the four-port SRAM arbiter.
interface sram_port_arbiter_if;
   logic [3:0]       Req;
   logic [3:0][17:0] Req_address;
   logic [3:0][15:0] Req_write_data;
   logic [3:0]       Req_we_n;
   logic [3:0]       Grant;
   logic [17:0]      SRAM_address;
   logic [15:0]      SRAM_write_data;
   logic             SRAM_we_n;
   logic [15:0]      SRAM_read_data;
   logic [15:0]      Read_data;
   logic [3:0]       Read_valid;
   logic             Busy;
   modport master (
      output Req, Req_address, Req_write_data, Req_we_n, SRAM_read_data,
      input  Grant, SRAM_address, SRAM_write_data, SRAM_we_n, Read_data, Read_valid, Busy
   );
   modport slave (
      input  Req, Req_address, Req_write_data, Req_we_n, SRAM_read_data,
      output Grant, SRAM_address, SRAM_write_data, SRAM_we_n, Read_data, Read_valid, Busy
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port among VGA (pre-emptive port 0) and round-robin,
// burst-limited ports 1-3; read returns are tagged and strobed back to the issuing port.
module sram_port_arbiter #(
   parameter int READ_LATENCY = 3,
   parameter int MAX_BURST    = 16
) (
   input logic Clock,
   input logic Resetn,
   sram_port_arbiter_if.slave bus
);
   localparam int P = READ_LATENCY - 1;
   localparam logic [8:0] MAXB = 9'(MAX_BURST);
   logic [3:0]        grant_q, grant_d, rv_q;
   logic [1:0]        rr_q, rr_d, sel, other, fresh;
   logic [7:0]        burst_q, burst_d;
   logic [8:0]        cnt;
   logic              acc, rd;
   logic [P-1:0]      tv_q;
   logic [P-1:0][1:0] tid_q;
   logic [15:0]       rdata_q;
   // first requesting port among 1..3 after p in rotating order (0 = none)
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] c;
      pick = 2'd0;
      c = p;
      for (int i = 0; i < 3; i++) begin
         c = (c == 2'd3) ? 2'd1 : c + 2'd1;
         if (r[c] && pick == 2'd0) pick = c;
      end
   endfunction
   always_comb begin
      sel     = grant_q[3] ? 2'd3 : grant_q[2] ? 2'd2 : grant_q[1] ? 2'd1 : 2'd0;
      acc     = |(grant_q & bus.Req);
      rd      = acc && bus.Req_we_n[sel];
      cnt     = {1'b0, burst_q} + {8'd0, acc && sel != 2'd0};
      other   = pick(bus.Req & ~(4'b0001 << sel), sel);
      fresh   = pick(bus.Req, rr_q);
      grant_d = bus.Req[0] ? 4'b0001 :
                (acc && sel != 2'd0) ? ((cnt < MAXB || other == 2'd0) ? grant_q : 4'b0001 << other) :
                (fresh != 2'd0) ? 4'b0001 << fresh : 4'b0000;
      rr_d    = grant_d[3] ? 2'd3 : grant_d[2] ? 2'd2 : grant_d[1] ? 2'd1 : rr_q;
      burst_d = (grant_d != grant_q) ? 8'd0 : (cnt > MAXB) ? MAXB[7:0] : cnt[7:0];
   end
   assign bus.Grant           = grant_q;
   assign bus.SRAM_we_n       = acc ? bus.Req_we_n[sel] : 1'b1;
   assign bus.SRAM_address    = acc ? bus.Req_address[sel] : 18'd0;
   assign bus.SRAM_write_data = acc ? bus.Req_write_data[sel] : 16'd0;
   assign bus.Read_valid      = rv_q;
   assign bus.Read_data       = rdata_q;
   assign bus.Busy            = |grant_q || |tv_q;
   // tag pipeline: SRAM data is captured as the tag leaves the last stage
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         grant_q <= 4'b0000;
         rr_q    <= 2'd3;
         burst_q <= 8'd0;
         tv_q    <= '0;
         tid_q   <= '0;
         rv_q    <= 4'b0000;
         rdata_q <= 16'd0;
      end else begin
         grant_q  <= grant_d;
         rr_q     <= rr_d;
         burst_q  <= burst_d;
         tv_q[0]  <= rd;
         tid_q[0] <= sel;
         for (int i = 1; i < P; i++) begin
            tv_q[i]  <= tv_q[i-1];
            tid_q[i] <= tid_q[i-1];
         end
         rv_q <= tv_q[P-1] ? 4'b0001 << tid_q[P-1] : 4'b0000;
         if (tv_q[P-1]) rdata_q <= bus.SRAM_read_data;
      end
   end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed and random stimulus checked cycle by cycle against a
// queue-based model of the arbitration rules and tagged read returns.
module tb_sram_port_arbiter;
   localparam int RL = 3;
   localparam int MB = 4;
   logic Clock = 1'b0;
   logic Resetn = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] we = 4'b1111;
   logic [3:0][17:0] ad = '0;
   logic [3:0][15:0] wd = '0;
   logic [17:0] hist [RL-1];
   sram_port_arbiter_if bus();
   sram_port_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MB)) dut (
      .Clock(Clock), .Resetn(Resetn), .bus(bus)
   );
   always #5 Clock = ~Clock;
   assign bus.Req = req;
   assign bus.Req_we_n = we;
   assign bus.Req_address = ad;
   assign bus.Req_write_data = wd;
   function automatic logic [15:0] mem(input logic [17:0] a);
      return a[15:0] ^ {a[17:16], a[17:16], 12'hA5C};
   endfunction
   // SRAM controller model: data for an address appears RL-1 cycles after it is presented
   always @(posedge Clock) begin
      hist[0] <= bus.SRAM_address;
      for (int i = 1; i < RL - 1; i++) hist[i] <= hist[i-1];
   end
   assign bus.SRAM_read_data = mem(hist[RL-2]);
   typedef struct { int due; int port; logic [15:0] data; } ret_t;
   ret_t q[$];
   int mg = -1, run = 0, last = 3, cyc = 0, errs = 0, checks = 0;
   logic [15:0] held = 16'd0;
   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errs++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, o, e);
      end
   endtask
   task automatic rnd();
      for (int i = 0; i < 4; i++) begin
         ad[i] = 18'($urandom);
         wd[i] = 16'($urandom);
      end
   endtask
   task automatic cycle();
      int n, p, ev;
      bit acc;
      @(negedge Clock);
      if (!Resetn) begin
         chk("rst_grant", bus.Grant, 0);
         chk("rst_valid", bus.Read_valid, 0);
         chk("rst_data", bus.Read_data, 0);
         chk("rst_busy", bus.Busy, 0);
         chk("rst_we_n", bus.SRAM_we_n, 1);
         chk("rst_addr", bus.SRAM_address, 0);
         chk("rst_wdata", bus.SRAM_write_data, 0);
         mg = -1; run = 0; last = 3; held = 16'd0;
         q.delete();
      end else begin
         acc = mg >= 0 && req[mg];
         chk("grant", bus.Grant, mg < 0 ? 0 : 1 << mg);
         chk("we_n", bus.SRAM_we_n, acc ? we[mg] : 1);
         chk("addr", bus.SRAM_address, acc ? ad[mg] : 0);
         chk("wdata", bus.SRAM_write_data, acc ? wd[mg] : 0);
         ev = 0;
         if (q.size() > 0 && q[0].due == cyc) begin
            ev = 1 << q[0].port;
            held = q[0].data;
            void'(q.pop_front());
         end
         chk("read_valid", bus.Read_valid, ev);
         chk("read_data", bus.Read_data, held);
         if (ev == 0) chk("busy", bus.Busy, (mg >= 0 || q.size() > 0) ? 1 : 0);
         if (acc && we[mg]) q.push_back('{due: cyc + RL, port: mg, data: mem(ad[mg])});
         if (req[0]) n = 0;
         else if (mg >= 1 && req[mg]) begin
            n = mg;
            if (run + 1 >= MB)
               for (int s = 1; s <= 2; s++) begin
                  p = (mg - 1 + s) % 3 + 1;
                  if (req[p] && n == mg) n = p;
               end
         end else begin
            n = -1;
            for (int s = 1; s <= 3; s++) begin
               p = (last - 1 + s) % 3 + 1;
               if (req[p] && n < 0) n = p;
            end
         end
         if (n != mg) run = 0;
         else if (acc && mg >= 1) run = (run + 1 > MB) ? MB : run + 1;
         if (n >= 1) last = n;
         mg = n;
      end
      @(posedge Clock);
      #1;
      cyc++;
   endtask
   initial begin
      repeat (3) cycle();
      Resetn = 1'b1;
      repeat (2) cycle();
      req = 4'b0100; we = 4'b1111; ad[2] = 18'h00100;
      repeat (2) cycle();
      req = 4'b0000;
      repeat (RL + 2) cycle();
      req = 4'b0010; we = 4'b1101;
      repeat (6) begin rnd(); cycle(); end
      req = 4'b0011; we = 4'b1100;
      repeat (5) begin rnd(); cycle(); end
      req = 4'b0010;
      repeat (3) begin rnd(); cycle(); end
      req = 4'b0000;
      repeat (RL + 2) cycle();
      req = 4'b1010;
      repeat (20) begin rnd(); we = 4'($urandom); cycle(); end
      req = 4'b0100; we = 4'b1111;
      repeat (52) begin rnd(); cycle(); end
      req = 4'b0000;
      repeat (RL + 2) cycle();
      req = 4'b1000; we = 4'b1111; ad[3] = 18'h3FFFF;
      repeat (2) cycle();
      ad[3] = 18'h00000; req = 4'b1001; ad[0] = 18'h12345;
      cycle();
      req = 4'b0001;
      repeat (3) begin ad[0] = 18'($urandom); cycle(); end
      req = 4'b0000;
      repeat (RL + 2) cycle();
      repeat (300) begin
         rnd();
         req = 4'($urandom);
         we = 4'($urandom);
         cycle();
      end
      req = 4'b0000;
      repeat (RL + 2) cycle();
      req = 4'b0010; we = 4'b1111;
      repeat (3) begin rnd(); cycle(); end
      Resetn = 1'b0;
      repeat (2) cycle();
      Resetn = 1'b1; req = 4'b0000;
      repeat (RL + 4) cycle();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
